// File: rtl/dp_ram_core.sv
// rtl/dp_ram_core.sv - true dual-port RAM core with read-first ports, port-A write priority,
// write-write collision reporting and out-of-range address flagging.
module dp_ram_core #(
   parameter int DATA_WIDTH = 8,
   parameter int MEM_DEPTH  = 16,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_ena,
   input  logic                  i_enb,
   input  logic                  i_wea,
   input  logic                  i_web,
   input  logic [ADDR_WIDTH-1:0] i_addra,
   input  logic [ADDR_WIDTH-1:0] i_addrb,
   input  logic [DATA_WIDTH-1:0] i_dina,
   input  logic [DATA_WIDTH-1:0] i_dinb,
   output logic [DATA_WIDTH-1:0] o_douta,
   output logic [DATA_WIDTH-1:0] o_doutb,
   output logic                  o_valida,
   output logic                  o_validb,
   output logic                  o_collision,
   output logic                  o_addr_err,
   output logic [7:0]            o_coll_count
);

   logic [DATA_WIDTH-1:0] mem [0:MEM_DEPTH-1];

   logic a_in_range, b_in_range;
   logic a_write, b_write, a_read, b_read;
   logic collide, addr_err_now;

   // MEM_DEPTH need not be a power of two, so the top of the address space can be unmapped
   assign a_in_range = (32'(i_addra) < MEM_DEPTH);
   assign b_in_range = (32'(i_addrb) < MEM_DEPTH);

   assign a_write = i_ena & i_wea & a_in_range;
   assign b_write = i_enb & i_web & b_in_range;
   assign a_read  = i_ena & ~i_wea;
   assign b_read  = i_enb & ~i_web;

   assign collide      = a_write & b_write & (i_addra == i_addrb);
   assign addr_err_now = (i_ena & ~a_in_range) | (i_enb & ~b_in_range);

   // Port B yields to port A when both write the same word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (a_write)            mem[i_addra] <= i_dina;
         if (b_write && !collide) mem[i_addrb] <= i_dinb;
      end
   end

   // Reads sample the array before this edge's writes land, giving read-first behaviour
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_douta  <= '0;
         o_doutb  <= '0;
         o_valida <= 1'b0;
         o_validb <= 1'b0;
      end else begin
         o_valida <= a_read;
         o_validb <= b_read;
         if (a_read) o_douta <= a_in_range ? mem[i_addra] : '0;
         if (b_read) o_doutb <= b_in_range ? mem[i_addrb] : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_collision  <= 1'b0;
         o_addr_err   <= 1'b0;
         o_coll_count <= '0;
      end else begin
         o_collision <= collide;
         o_addr_err  <= addr_err_now;
         if (collide && o_coll_count != 8'hFF) o_coll_count <= o_coll_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_dp_ram_core.sv
// tb/tb_dp_ram_core.sv - scoreboard bench for dp_ram_core: directed vectors with hand-derived
// expectations, an asynchronous reset scenario and a randomised run against a reference model.
module tb_dp_ram_core;

   localparam int DW    = 8;
   localparam int DEPTH = 12;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ena = 1'b0, enb = 1'b0, wea = 1'b0, web = 1'b0;
   logic [AW-1:0] addra = '0, addrb = '0;
   logic [DW-1:0] dina = '0, dinb = '0;
   logic [DW-1:0] douta, doutb;
   logic          valida, validb, collision, addr_err;
   logic [7:0]    coll_count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [DW-1:0] douta;
      logic [DW-1:0] doutb;
      logic          va;
      logic          vb;
      logic          coll;
      logic          aerr;
      logic [7:0]    cnt;
   } exp_t;

   exp_t exp_q[$];

   // reference model state for the randomised phase
   logic [DW-1:0] m_mem [0:DEPTH-1];
   logic [DW-1:0] m_douta, m_doutb;
   logic [7:0]    m_cnt;

   dp_ram_core #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .i_ena(ena), .i_enb(enb), .i_wea(wea), .i_web(web),
      .i_addra(addra), .i_addrb(addrb), .i_dina(dina), .i_dinb(dinb),
      .o_douta(douta), .o_doutb(doutb), .o_valida(valida), .o_validb(validb),
      .o_collision(collision), .o_addr_err(addr_err), .o_coll_count(coll_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: one expectation per serviced request cycle, sampled after the edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("douta", 32'(douta), 32'(e.douta));
            check("doutb", 32'(doutb), 32'(e.doutb));
            check("valida", 32'(valida), 32'(e.va));
            check("validb", 32'(validb), 32'(e.vb));
            check("collision", 32'(collision), 32'(e.coll));
            check("addr_err", 32'(addr_err), 32'(e.aerr));
            check("coll_count", 32'(coll_count), 32'(e.cnt));
         end
      end
   end

   task automatic drive(input logic ea, wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic eb, wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
      @(negedge clk);
      ena = ea; wea = wa; addra = aa; dina = da;
      enb = eb; web = wb; addrb = ab; dinb = db;
   endtask

   task automatic step(input logic ea, wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                       input logic eb, wb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                       input logic [DW-1:0] xa, xb, input logic xva, xvb, xcoll, xerr,
                       input logic [7:0] xcnt);
      exp_t e;
      drive(ea, wa, aa, da, eb, wb, ab, db);
      e.douta = xa; e.doutb = xb; e.va = xva; e.vb = xvb;
      e.coll = xcoll; e.aerr = xerr; e.cnt = xcnt;
      exp_q.push_back(e);
   endtask

   task automatic model_step(input logic ea, wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                             input logic eb, wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
      exp_t e;
      logic oka, okb, coll;
      drive(ea, wa, aa, da, eb, wb, ab, db);
      oka = (int'(aa) < DEPTH);
      okb = (int'(ab) < DEPTH);
      e.va = ea & ~wa;
      e.vb = eb & ~wb;
      if (e.va) m_douta = oka ? m_mem[aa] : '0;
      if (e.vb) m_doutb = okb ? m_mem[ab] : '0;
      coll = ea & wa & eb & wb & oka & okb & (aa == ab);
      e.douta = m_douta;
      e.doutb = m_doutb;
      e.coll  = coll;
      e.aerr  = (ea & ~oka) | (eb & ~okb);
      if (coll && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      e.cnt = m_cnt;
      if (ea && wa && oka) m_mem[aa] = da;
      if (eb && wb && okb && !coll) m_mem[ab] = db;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
      #2;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic idle();
      @(negedge clk);
      ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0;
   endtask

   initial begin
      // held in reset: everything at zero regardless of clock
      #22;
      check("rst_douta", 32'(douta), 32'd0);
      check("rst_doutb", 32'(doutb), 32'd0);
      check("rst_valid", 32'({valida, validb, collision, addr_err}), 32'd0);
      check("rst_coll_count", 32'(coll_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      //    ea wa aa     da     eb wb ab     db       xa     xb    va vb co er cnt
      step(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00,   8'h00, 8'h00, 0, 0, 0, 0, 8'd0);
      step(0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00,   8'h00, 8'hA5, 0, 1, 0, 0, 8'd0);
      step(1, 1, 4'd5, 8'h11, 0, 0, 4'd0, 8'h00,   8'h00, 8'hA5, 0, 0, 0, 0, 8'd0);
      step(1, 1, 4'd5, 8'h22, 1, 0, 4'd5, 8'h00,   8'h00, 8'h11, 0, 1, 0, 0, 8'd0);
      step(1, 0, 4'd5, 8'h00, 0, 0, 4'd0, 8'h00,   8'h22, 8'h11, 1, 0, 0, 0, 8'd0);
      step(1, 1, 4'd7, 8'hAA, 1, 1, 4'd7, 8'h55,   8'h22, 8'h11, 0, 0, 1, 0, 8'd1);
      step(1, 0, 4'd7, 8'h00, 1, 0, 4'd7, 8'h00,   8'hAA, 8'hAA, 1, 1, 0, 0, 8'd1);
      step(1, 1, 4'd13, 8'hFF, 0, 0, 4'd0, 8'h00,  8'hAA, 8'hAA, 0, 0, 0, 1, 8'd1);
      step(0, 0, 4'd0, 8'h00, 1, 0, 4'd13, 8'h00,  8'hAA, 8'h00, 0, 1, 0, 1, 8'd1);
      step(1, 0, 4'd13, 8'h00, 1, 0, 4'd12, 8'h00, 8'h00, 8'h00, 1, 1, 0, 1, 8'd1);

      // in-range contents after the out-of-range write: only 3, 5, 7 were ever written
      for (int i = 0; i < DEPTH; i++) begin
         logic [DW-1:0] v;
         v = (i == 3) ? 8'hA5 : (i == 5) ? 8'h22 : (i == 7) ? 8'hAA : 8'h00;
         step(1, 0, AW'(i), 8'h00, 0, 0, 4'd0, 8'h00, v, 8'h00, 1, 0, 0, 0, 8'd1);
      end

      // 300 more collisions on addr 7; count started at 1 and must stop at FF
      for (int i = 0; i < 300; i++) begin
         logic [7:0] c;
         c = (i + 2 > 255) ? 8'hFF : 8'(i + 2);
         step(1, 1, 4'd7, 8'(i), 1, 1, 4'd7, 8'hEE, 8'h00, 8'h00, 0, 0, 1, 0, c);
      end
      step(1, 1, 4'd13, 8'h01, 1, 1, 4'd13, 8'h02, 8'h00, 8'h00, 0, 0, 0, 1, 8'hFF);
      step(1, 0, 4'd7, 8'h00, 1, 0, 4'd7, 8'h00,   8'h2B, 8'h2B, 1, 1, 0, 0, 8'hFF);
      step(1, 1, 4'd1, 8'h01, 1, 1, 4'd2, 8'h02,   8'h2B, 8'h2B, 0, 0, 0, 0, 8'hFF);
      step(1, 0, 4'd2, 8'h00, 1, 0, 4'd1, 8'h00,   8'h02, 8'h01, 1, 1, 0, 0, 8'hFF);
      step(1, 0, 4'd7, 8'h00, 1, 0, 4'd3, 8'h00,   8'h2B, 8'hA5, 1, 1, 0, 0, 8'hFF);
      drain();

      // asynchronous reset with a read presented but not yet clocked
      drive(1, 0, 4'd3, 8'h00, 1, 1, 4'd4, 8'h77);
      #2 rst = 1'b1;
      #1;
      check("async_rst_douta", 32'(douta), 32'd0);
      check("async_rst_doutb", 32'(doutb), 32'd0);
      check("async_rst_flags", 32'({valida, validb, collision, addr_err}), 32'd0);
      check("async_rst_coll_count", 32'(coll_count), 32'd0);
      @(posedge clk);
      #1;
      check("rst_no_valid_pulse", 32'({valida, validb}), 32'd0);
      check("rst_hold_douta", 32'(douta), 32'd0);
      idle();
      rst = 1'b0;

      for (int i = 0; i < DEPTH; i++)
         step(1, 0, AW'(i), 8'h00, 1, 0, AW'(DEPTH - 1 - i), 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 8'd0);

      // randomised traffic against the reference model, starting from the cleared state
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_douta = '0;
      m_doutb = '0;
      m_cnt   = '0;
      for (int i = 0; i < 10000; i++) begin
         model_step(1'($urandom), 1'($urandom), AW'($urandom_range(0, 13)), 8'($urandom),
                    1'($urandom), 1'($urandom), AW'($urandom_range(0, 13)), 8'($urandom));
      end
      drain();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
